// File: rtl/ext_mem_responder.sv
// Purpose: memory-side responder on the MainCPU external bus, with a word RAM and programmable wait states (optional BusError via EXT_MEM_BUS_ERR_EN).
// Latency: ExternalExchangeReady rises WAIT_STATES+1 edges after the edge that captures a read/write request.
// Backpressure: Ready and read data are held until MemIO is sampled 00; a new request needs at least one idle cycle.
module ext_mem_responder #(
    parameter int          DEPTH       = 256,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  MemIO,
    input  logic [31:0] ExternalAddressBus,
    inout  wire  [31:0] ExternalDataBus,
    output logic        ExternalExchangeReady,
`ifdef EXT_MEM_BUS_ERR_EN
    output logic        BusError,
`endif
    output logic        Busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t      state;
    state_t      stateNext;
    logic [3:0]  waitCnt;
    logic [3:0]  waitCntNext;
    logic        enterAck;
    logic        captureReq;

    logic [31:0] latAddr;
    logic [31:0] latData;
    logic        latWrite;
    logic [31:0] outReg;

    logic [29:0]   wordOff;
    logic [AW-1:0] memIdx;
    logic          inRange;

    logic [31:0] mem [DEPTH];

    // Range is judged on the latched address, so bus changes during WAIT cannot affect it.
    assign wordOff = 30'((latAddr - BASE_ADDR) >> 2);
    assign memIdx  = wordOff[AW-1:0];
    assign inRange = (latAddr >= BASE_ADDR) && (wordOff < 30'(DEPTH));

    assign captureReq = (state == IDLE) && ((MemIO == 2'b01) || (MemIO == 2'b10));

    // WAIT also spends the single access cycle, which gives WAIT_STATES+1 edges to Ready
    // (one edge when WAIT_STATES is zero).
    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        enterAck    = 1'b0;
        case (state)
            IDLE: begin
                if (captureReq) begin
                    stateNext   = WAIT;
                    waitCntNext = 4'(WAIT_STATES);
                end
            end
            WAIT: begin
                if (waitCnt == 4'd0) begin
                    stateNext = ACK;
                    enterAck  = 1'b1;
                end else begin
                    waitCntNext = waitCnt - 4'd1;
                end
            end
            ACK: begin
                if (MemIO == 2'b00) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            waitCnt  <= 4'd0;
            latAddr  <= 32'h0;
            latData  <= 32'h0;
            latWrite <= 1'b0;
            outReg   <= 32'h0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
            if (captureReq) begin
                latAddr  <= ExternalAddressBus;
                latData  <= ExternalDataBus;
                latWrite <= (MemIO == 2'b10);
            end
            if (enterAck && !latWrite) begin
                outReg <= inRange ? mem[memIdx] : 32'h0;
            end
        end
    end

    // RAM contents survive reset, but a write landing on a reset edge is suppressed.
    always_ff @(posedge clk) begin
        if (!rst && enterAck && latWrite && inRange) begin
            mem[memIdx] <= latData;
        end
    end

    assign ExternalExchangeReady = (state == ACK);
    assign Busy                  = (state != IDLE);
    assign ExternalDataBus       = ((state == ACK) && !latWrite) ? outReg : 32'hz;

`ifdef EXT_MEM_BUS_ERR_EN
    assign BusError = (state == ACK) && !inRange;
`endif

endmodule

// File: tb/tb_ext_mem_responder.sv
// Directed bench: one responder with two wait states and one with none see identical bus traffic.
module tb_ext_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  memIo;
    logic [31:0] addr;
    logic        tbDrive;
    logic [31:0] tbData;
    wire  [31:0] busA;
    wire  [31:0] busB;
    logic        rdyA, rdyB, busyA, busyB;
`ifdef EXT_MEM_BUS_ERR_EN
    logic        errA, errB;
`endif

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    assign busA = tbDrive ? tbData : 32'hz;
    assign busB = tbDrive ? tbData : 32'hz;

    ext_mem_responder #(.DEPTH(256), .WAIT_STATES(2), .BASE_ADDR(32'h0)) dutA (
        .clk                   (clk),
        .rst                   (rst),
        .MemIO                 (memIo),
        .ExternalAddressBus    (addr),
        .ExternalDataBus       (busA),
        .ExternalExchangeReady (rdyA),
`ifdef EXT_MEM_BUS_ERR_EN
        .BusError              (errA),
`endif
        .Busy                  (busyA)
    );

    ext_mem_responder #(.DEPTH(256), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dutB (
        .clk                   (clk),
        .rst                   (rst),
        .MemIO                 (memIo),
        .ExternalAddressBus    (addr),
        .ExternalDataBus       (busB),
        .ExternalExchangeReady (rdyB),
`ifdef EXT_MEM_BUS_ERR_EN
        .BusError              (errB),
`endif
        .Busy                  (busyB)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] expRd;
        logic        expErr;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the edge where Ready falls.
    task automatic xfer(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] expRd, input logic expErr,
                        input int hold);
        int edges = 0;
        int riseA = 0;
        int riseB = 0;
        logic [31:0] rdA = 32'h0;
        logic [31:0] rdB = 32'h0;
        logic eA = 1'b0;
        logic eB = 1'b0;
        memIo   = op;
        addr    = a;
        tbDrive = (op == 2'b10);
        tbData  = wd;
        @(posedge clk); #1;
        check({name, " busyA after capture"}, 32'(busyA), 32'd1);
        // Disturb address/data while waiting: only the captured values may be used.
        addr   = a ^ 32'h4;
        tbData = ~wd;
        while ((riseA == 0 || riseB == 0) && edges < 20) begin
            @(posedge clk); #1;
            edges++;
            if (rdyA && riseA == 0) begin
                riseA = edges;
                rdA   = busA;
`ifdef EXT_MEM_BUS_ERR_EN
                eA    = errA;
`endif
            end
            if (rdyB && riseB == 0) begin
                riseB = edges;
                rdB   = busB;
`ifdef EXT_MEM_BUS_ERR_EN
                eB    = errB;
`endif
            end
        end
        check({name, " latency ws2"}, 32'(riseA), 32'd3);
        check({name, " latency ws0"}, 32'(riseB), 32'd1);
        if (op == 2'b01) begin
            check({name, " rdata ws2"}, rdA, expRd);
            check({name, " rdata ws0"}, rdB, expRd);
        end
`ifdef EXT_MEM_BUS_ERR_EN
        check({name, " buserr ws2"}, 32'(eA), 32'(expErr));
        check({name, " buserr ws0"}, 32'(eB), 32'(expErr));
`else
        if (eA || eB || expErr) begin
            // Without the error output, out-of-range accesses are silent.
        end
`endif
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check($sformatf("%s hold%0d ready", name, i), 32'(rdyA), 32'd1);
            check($sformatf("%s hold%0d data", name, i), busA, expRd);
        end
        memIo   = 2'b00;
        tbDrive = 1'b0;
        @(posedge clk); #1;
        check({name, " ready fall ws2"}, 32'(rdyA), 32'd0);
        check({name, " ready fall ws0"}, 32'(rdyB), 32'd0);
        check({name, " busy idle"}, 32'(busyA), 32'd0);
`ifdef EXT_MEM_BUS_ERR_EN
        check({name, " buserr clear"}, 32'(errA), 32'd0);
`endif
    endtask

    initial begin
        int seen;
        vecs[0]  = '{2'b10, 32'h0000_0010, 32'd114691,     32'h0,         1'b0};
        vecs[1]  = '{2'b01, 32'h0000_0010, 32'h0,          32'h0001_C003, 1'b0};
        vecs[2]  = '{2'b10, 32'h0000_0000, 32'd1281,       32'h0,         1'b0};
        vecs[3]  = '{2'b01, 32'h0000_0000, 32'h0,          32'h0000_0501, 1'b0};
        vecs[4]  = '{2'b10, 32'h0000_0400, 32'hDEAD_BEEF,  32'h0,         1'b1};
        vecs[5]  = '{2'b01, 32'h0000_0400, 32'h0,          32'h0000_0000, 1'b1};
        vecs[6]  = '{2'b01, 32'h0000_0000, 32'h0,          32'h0000_0501, 1'b0};
        vecs[7]  = '{2'b10, 32'h0000_03FF, 32'h1234_5678,  32'h0,         1'b0};
        vecs[8]  = '{2'b01, 32'h0000_03FC, 32'h0,          32'h1234_5678, 1'b0};
        vecs[9]  = '{2'b10, 32'h0000_0020, 32'hCAFE_F00D,  32'h0,         1'b0};
        vecs[10] = '{2'b01, 32'h0000_0022, 32'h0,          32'hCAFE_F00D, 1'b0};

        // Reset held with a read request pending: nothing may respond or drive the bus.
        rst     = 1'b1;
        memIo   = 2'b01;
        addr    = 32'h0;
        tbDrive = 1'b1;
        tbData  = 32'hA5A5_5A5A;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check($sformatf("reset%0d ready", i), 32'({rdyA, rdyB}), 32'd0);
            check($sformatf("reset%0d busy", i), 32'({busyA, busyB}), 32'd0);
            check($sformatf("reset%0d busA released", i), busA, 32'hA5A5_5A5A);
            check($sformatf("reset%0d busB released", i), busB, 32'hA5A5_5A5A);
        end
        rst     = 1'b0;
        memIo   = 2'b00;
        tbDrive = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            xfer($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].wd,
                 vecs[i].expRd, vecs[i].expErr, 0);
        end

        xfer("holdoff", 2'b01, 32'h10, 32'h0, 32'h0001_C003, 1'b0, 5);

        // Reserved code is never acknowledged.
        memIo = 2'b11;
        addr  = 32'h10;
        seen  = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (rdyA || rdyB || busyA || busyB) seen++;
        end
        check("reserved code ignored", 32'(seen), 32'd0);
        memIo = 2'b00;
        @(posedge clk); #1;

        // Reset during WAIT of a write; for the zero-wait instance this is its ACK edge.
        memIo   = 2'b10;
        addr    = 32'h20;
        tbDrive = 1'b1;
        tbData  = 32'h1111_1111;
        @(posedge clk); #1;
        check("midreset busy before", 32'({busyA, busyB}), 32'd3);
        rst     = 1'b1;
        memIo   = 2'b00;
        tbDrive = 1'b0;
        @(posedge clk); #1;
        check("midreset state", 32'({rdyA, rdyB, busyA, busyB}), 32'd0);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (rdyA || rdyB) seen++;
        end
        check("midreset ready never rises", 32'(seen), 32'd0);
        xfer("midreset readback", 2'b01, 32'h20, 32'h0, 32'hCAFE_F00D, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
